dev_swio_resp: RTL

DEV_SWIO_RESP -- requirements
Module: dev_swio_resp

---
 rtl/dev_swio_resp_if.sv | 42 ++++
 rtl/dev_swio_resp.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_swio_resp_if.sv
// ============================================================================
// dev_swio_resp_if
// ----------------------------------------------------------------------------
// Purpose : Z80-style I/O bus between a CPU-side requester and the switched-I/O
//           responder (dev_swio_resp).
//
// Signals :
//   req        requester -> device  single-cycle request strobe
//   iorq, m1   requester -> device  Z80 cycle qualifiers
//   rd, wr     requester -> device  read / write qualifiers
//   addr[7:0]  requester -> device  I/O address (low byte)
//   data_in    requester -> device  CPU write data
//   data_out   device -> requester  read data, held between reads
//   data_oe    device -> requester  device drives the read data
//   wait_n     device -> requester  low while a read is pending
//   data_valid device -> requester  one-cycle pulse, data_out valid
//
// Modports: master (CPU side), slave (device side).
// ============================================================================
interface dev_swio_resp_if;
    logic       req;
    logic       iorq;
    logic       m1;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       wait_n;
    logic       data_valid;

    modport master (
        output req, iorq, m1, rd, wr, addr, data_in,
        input  data_out, data_oe, wait_n, data_valid
    );

    modport slave (
        input  req, iorq, m1, rd, wr, addr, data_in,
        output data_out, data_oe, wait_n, data_valid
    );
endinterface

// File: rtl/dev_swio_resp.sv
// ============================================================================
// dev_swio_resp
// ----------------------------------------------------------------------------
// Purpose : Switched-I/O device responder for the 40h-4Fh port window
//           (1chipMSX style). Port 40h selects a device ID; the selected
//           device exposes its registers on 41h-4Fh.
//             ID_MAIN : 41h-47h scratch bytes, 48h write counter (read only),
//                       4Eh/4Fh write-only configuration latches (only while
//                       the IPL is loading, ldbios_n = 0).
//             ID_ALT  : 41h single R/W byte (optional feature).
//           Writes complete on the accepting edge. Reads go through a small
//           IDLE -> WAIT -> VALID sequencer that inserts RD_LATENCY wait
//           cycles before presenting data.
//
// Optional feature macro: SWIO_ALT_ID_EN
//   defined   : ID_ALT can be selected and its 41h register exists.
//   undefined : writing ID_ALT to 40h deselects (sel_id = FFh).
//
// Parameters:
//   ID_MAIN    primary device ID (default D4h)
//   ID_ALT     secondary device ID (default 08h, SWIO_ALT_ID_EN only)
//   RD_LATENCY wait cycles before read data is valid, 1..7
//
// Ports:
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   bus          dev_swio_resp_if.slave I/O bus
//   ldbios_n     low = IPL loading, 4Eh/4Fh unlocked
//   jis2_ena     configuration latch (4Eh)
//   portf4_mode  configuration latch (4Fh)
//   warm_logo    configuration latch (4Fh)
//   err_ovr      sticky: a read arrived while another was in progress
// ============================================================================
module dev_swio_resp #(
    parameter logic [7:0] ID_MAIN    = 8'hD4,
    parameter logic [7:0] ID_ALT     = 8'h08,
    parameter int         RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    dev_swio_resp_if.slave  bus,
    input  logic            ldbios_n,
    output logic            jis2_ena,
    output logic            portf4_mode,
    output logic            warm_logo,
    output logic            err_ovr
);

`ifdef SWIO_ALT_ID_EN
    localparam bit ALT_EN = 1'b1;
`else
    localparam bit ALT_EN = 1'b0;
`endif

    // WAIT is held for RD_LATENCY cycles: counter runs RD_LATENCY-1 down to 0.
    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } rd_state_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       wr_acc;
    logic       rd_acc;
    logic [3:0] port_lo;

    assign hit     = bus.req & bus.iorq & ~bus.m1 & (bus.addr[7:4] == 4'h4);
    assign port_lo = bus.addr[3:0];
    // When rd and wr are both asserted the write takes priority.
    assign wr_acc  = hit & bus.wr;
    assign rd_acc  = hit & bus.rd & ~bus.wr;

    logic [7:0] sel_id_reg;
    logic       main_sel;
    logic       alt_sel;
    logic       id_ok;
    logic       wr_main;
    logic       wr_scratch;

    assign main_sel   = (sel_id_reg == ID_MAIN);
    assign alt_sel    = ALT_EN && (sel_id_reg == ID_ALT);
    assign id_ok      = (bus.data_in == ID_MAIN) || (ALT_EN && (bus.data_in == ID_ALT));
    assign wr_main    = wr_acc & main_sel;
    assign wr_scratch = wr_main & (port_lo != 4'h0) & (port_lo <= 4'h7);

    // ------------------------------------------------------------------
    // Device select register (port 40h)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_id_reg <= 8'hFF;
        end else if (wr_acc && port_lo == 4'h0) begin
            // Unknown IDs deselect every device.
            sel_id_reg <= id_ok ? bus.data_in : 8'hFF;
        end
    end

    // ------------------------------------------------------------------
    // ID_MAIN scratch bytes, ports 41h-47h (indexed by port low nibble)
    // ------------------------------------------------------------------
    logic [7:0] scratch_q [1:7];

    generate
        for (gi = 1; gi <= 7; gi++) begin : g_scratch
            logic [7:0] byte_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    byte_reg <= 8'h00;
                end else if (wr_main && port_lo == 4'(gi)) begin
                    byte_reg <= bus.data_in;
                end
            end
            assign scratch_q[gi] = byte_reg;
        end
    endgenerate

    // Count of accepted scratch writes, port 48h; free-running 8-bit wrap.
    logic [7:0] wcount_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcount_reg <= 8'h00;
        end else if (wr_scratch) begin
            wcount_reg <= wcount_reg + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Configuration latches, ports 4Eh/4Fh (inverted bit 7, IPL only)
    // ------------------------------------------------------------------
    logic cfg_wr_en;
    logic jis2_ena_reg;
    logic portf4_mode_reg;
    logic warm_logo_reg;

    assign cfg_wr_en = wr_main & ~ldbios_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jis2_ena_reg    <= 1'b0;
            portf4_mode_reg <= 1'b0;
            warm_logo_reg   <= 1'b0;
        end else if (cfg_wr_en) begin
            if (port_lo == 4'hE) begin
                jis2_ena_reg <= ~bus.data_in[7];
            end
            if (port_lo == 4'hF) begin
                portf4_mode_reg <= ~bus.data_in[7];
                warm_logo_reg   <= ~bus.data_in[7];
            end
        end
    end

    assign jis2_ena    = jis2_ena_reg;
    assign portf4_mode = portf4_mode_reg;
    assign warm_logo   = warm_logo_reg;

    // ------------------------------------------------------------------
    // ID_ALT register, port 41h
    // ------------------------------------------------------------------
    logic [7:0] alt_data;

`ifdef SWIO_ALT_ID_EN
    logic [7:0] alt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alt_reg <= 8'h00;
        end else if (wr_acc && alt_sel && port_lo == 4'h1) begin
            alt_reg <= bus.data_in;
        end
    end

    assign alt_data = alt_reg;
`else
    // No storage; alt_sel is constant 0 so this value is never returned.
    assign alt_data = 8'hFF;
`endif

    // ------------------------------------------------------------------
    // Read multiplexer: value a read would return right now
    // ------------------------------------------------------------------
    logic [7:0] rd_mux_data;
    logic       rd_mux_oe;

    always_comb begin
        rd_mux_data = 8'hFF;
        rd_mux_oe   = 1'b0;
        if (port_lo == 4'h0) begin
            if (sel_id_reg != 8'hFF) begin
                rd_mux_data = ~sel_id_reg;
                rd_mux_oe   = 1'b1;
            end
        end else if (main_sel) begin
            if (port_lo <= 4'h7) begin
                rd_mux_oe = 1'b1;
                for (int i = 1; i <= 7; i++) begin
                    if (port_lo == 4'(i)) begin
                        rd_mux_data = scratch_q[i];
                    end
                end
            end else if (port_lo == 4'h8) begin
                rd_mux_data = wcount_reg;
                rd_mux_oe   = 1'b1;
            end else if (port_lo >= 4'hE) begin
                // Write-only latches answer with FFh but still drive the bus.
                rd_mux_oe = 1'b1;
            end
        end else if (alt_sel && port_lo == 4'h1) begin
            rd_mux_data = alt_data;
            rd_mux_oe   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    rd_state_t  state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       cap_load;
    logic       out_load;
    logic       ovr_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cap_load   = 1'b0;
        out_load   = 1'b0;
        ovr_hit    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rd_acc) begin
                    state_next = ST_WAIT;
                    cnt_next   = LAT_M1;
                    cap_load   = 1'b1;
                end
            end
            ST_WAIT: begin
                ovr_hit = rd_acc;
                if (cnt_reg == 3'd0) begin
                    state_next = ST_VALID;
                    // Present data on entry so it is valid with data_valid.
                    out_load   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_VALID: begin
                ovr_hit    = rd_acc;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Data is snapshotted at the accept edge so writes issued while the
    // read is waiting cannot change what the CPU sees.
    logic [7:0] cap_data_reg;
    logic       cap_oe_reg;
    logic [7:0] dout_reg;
    logic       doe_reg;
    logic       err_ovr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_data_reg <= 8'hFF;
            cap_oe_reg   <= 1'b0;
            dout_reg     <= 8'hFF;
            doe_reg      <= 1'b0;
            err_ovr_reg  <= 1'b0;
        end else begin
            if (cap_load) begin
                cap_data_reg <= rd_mux_data;
                cap_oe_reg   <= rd_mux_oe;
            end
            if (out_load) begin
                dout_reg <= cap_data_reg;
                doe_reg  <= cap_oe_reg;
            end
            if (ovr_hit) begin
                err_ovr_reg <= 1'b1;
            end
        end
    end

    assign bus.data_out   = dout_reg;
    assign bus.data_oe    = doe_reg;
    assign bus.wait_n     = (state_reg != ST_WAIT);
    assign bus.data_valid = (state_reg == ST_VALID);
    assign err_ovr        = err_ovr_reg;

endmodule
